// File: rtl/button_pio_pkg.sv
// Shared constants for the button PIO master.
// Register offsets of the PIO slave and the FSM state encoding.
package button_pio_pkg;

    localparam logic [1:0] PIO_DATA     = 2'd0;
    localparam logic [1:0] PIO_IRQ_MASK = 2'd2;
    localparam logic [1:0] PIO_EDGE_CAP = 2'd3;

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        IDLE     = 3'd1,
        RD_EDGE  = 3'd2,
        CAP_EDGE = 3'd3,
        CLR      = 3'd4,
        RD_LVL   = 3'd5,
        CAP_LVL  = 3'd6,
        OUT      = 3'd7
    } state_t;

endpackage

// File: rtl/button_pio_master.sv
// Button PIO master: on irq reads and clears the edge capture register,
// reads the button levels, and offers the result as a valid/ready event.
module button_pio_master
    import button_pio_pkg::*;
#(
    parameter int unsigned      WIDTH    = 4,
    parameter logic [WIDTH-1:0] IRQ_MASK = WIDTH'(4'hF)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             irq,
    input  logic [31:0]      readdata,
    output logic             chipselect,
    output logic [1:0]       address,
    output logic             write_n,
    output logic [31:0]      writedata,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [WIDTH-1:0] ev_edges,
    output logic [WIDTH-1:0] ev_levels,
    output logic [15:0]      ev_count
);

    state_t           state;
    state_t           state_nxt;
    logic             run;
    logic             irq_q;
    logic             take;
    logic [WIDTH-1:0] edges_q;
    logic [WIDTH-1:0] levels_q;
    logic             rd_unused;

    assign take      = ev_valid && ev_ready;
    assign ev_edges  = edges_q;
    assign ev_levels = levels_q;
    assign rd_unused = ^(readdata >> WIDTH);

    // State register; run holds INIT idle until the first clock after
    // reset so the bus stays quiet while reset_n is low. irq is
    // registered at the boundary before the FSM looks at it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
            run   <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
            irq_q <= irq;
        end
    end

    // Next state, PIO bus outputs and event valid.
    always_comb begin
        state_nxt  = state;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = PIO_DATA;
        writedata  = '0;
        ev_valid   = 1'b0;
        unique case (state)
            INIT: begin
                if (run) begin
                    chipselect = 1'b1;
                    write_n    = 1'b0;
                    address    = PIO_IRQ_MASK;
                    writedata  = 32'(IRQ_MASK);
                    state_nxt  = IDLE;
                end
            end
            IDLE: begin
                if (irq_q) state_nxt = RD_EDGE;
            end
            RD_EDGE: begin
                chipselect = 1'b1;
                address    = PIO_EDGE_CAP;
                state_nxt  = CAP_EDGE;
            end
            CAP_EDGE: begin
                chipselect = 1'b1;
                address    = PIO_EDGE_CAP;
                state_nxt  = CLR;
            end
            CLR: begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                address    = PIO_EDGE_CAP;
                state_nxt  = RD_LVL;
            end
            RD_LVL: begin
                chipselect = 1'b1;
                state_nxt  = CAP_LVL;
            end
            CAP_LVL: begin
                chipselect = 1'b1;
                state_nxt  = (edges_q == '0) ? IDLE : OUT;
            end
            OUT: begin
                ev_valid = 1'b1;
                if (ev_ready) state_nxt = IDLE;
            end
            default: state_nxt = INIT;
        endcase
    end

    // Capture edges and levels from the read data, count accepted events.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edges_q  <= '0;
            levels_q <= '0;
            ev_count <= '0;
        end else begin
            if (state == CAP_EDGE)
                edges_q <= readdata[WIDTH-1:0] & IRQ_MASK;
            if (state == CAP_LVL)
                levels_q <= readdata[WIDTH-1:0];
            if (take)
                ev_count <= ev_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_button_pio_master.sv
// Bench for button_pio_master: a small PIO slave model plus a scoreboard
// of expected events checked when the DUT hands them over.
module tb_button_pio_master;

    logic        clk;
    logic        reset_n;
    logic        irq;
    logic [31:0] readdata;
    logic        chipselect;
    logic [1:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic        ev_valid;
    logic        ev_ready;
    logic [3:0]  ev_edges;
    logic [3:0]  ev_levels;
    logic [15:0] ev_count;

    button_pio_master #(
        .WIDTH    (4),
        .IRQ_MASK (4'hF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .irq        (irq),
        .readdata   (readdata),
        .chipselect (chipselect),
        .address    (address),
        .write_n    (write_n),
        .writedata  (writedata),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_edges   (ev_edges),
        .ev_levels  (ev_levels),
        .ev_count   (ev_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  e;
        logic [3:0]  l;
        logic [15:0] c;
    } ev_t;

    ev_t         sb[$];
    ev_t         x;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_cnt;
    logic        cnt_pend;
    logic [15:0] cnt_exp;

    logic [3:0]  pio_edge;
    logic [3:0]  pio_data;
    logic [3:0]  pio_mask;
    logic [3:0]  inj;
    logic        irq_force;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // PIO slave: edge capture, mask register, registered read data
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pio_edge <= 4'h0;
            pio_mask <= 4'h0;
        end else begin
            if (chipselect && !write_n && address == 2'd3)
                pio_edge <= 4'h0;
            else
                pio_edge <= pio_edge | inj;
            if (chipselect && !write_n && address == 2'd2)
                pio_mask <= writedata[3:0];
        end
    end

    always @(posedge clk) begin
        if (address == 2'd3)
            readdata <= {28'h0, pio_edge};
        else if (address == 2'd0)
            readdata <= {28'h0, pio_data};
        else
            readdata <= 32'h0;
    end

    assign irq = (|(pio_edge & pio_mask)) | irq_force;

    // Scoreboard: pop on each handshake, ev_count checked a cycle later
    always @(negedge clk) begin
        if (cnt_pend) begin
            check("ev_count", 32'(ev_count), 32'(cnt_exp));
            cnt_pend = 1'b0;
        end
        if (reset_n && ev_valid && ev_ready) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                x = sb.pop_front();
                check("ev_edges", 32'(ev_edges), 32'(x.e));
                check("ev_levels", 32'(ev_levels), 32'(x.l));
                cnt_exp  = x.c;
                cnt_pend = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [3:0] e, input logic [3:0] l);
        ev_t t;
        pio_data = l;
        inj      = e;
        exp_cnt  = exp_cnt + 16'd1;
        t.e = e;
        t.l = l;
        t.c = exp_cnt;
        sb.push_back(t);
        tick(1);
        inj = 4'h0;
    endtask

    task automatic wait_valid(input string tag, output int cyc);
        cyc = 0;
        while (!ev_valid && cyc < 40) begin
            tick(1);
            cyc++;
        end
        check(tag, 32'(ev_valid), 32'd1);
    endtask

    task automatic check_bus(input string tag,
                             input logic cs, input logic wn,
                             input logic [1:0] a, input logic [31:0] wd);
        check({tag, "_cs"}, 32'(chipselect), 32'(cs));
        check({tag, "_wn"}, 32'(write_n), 32'(wn));
        check({tag, "_addr"}, 32'(address), 32'(a));
        check({tag, "_wd"}, writedata, wd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    logic [4:0] seq[6];
    int         lat;
    int         found;

    initial begin
        reset_n   = 1'b0;
        ev_ready  = 1'b0;
        inj       = 4'h0;
        pio_data  = 4'h0;
        irq_force = 1'b0;
        exp_cnt   = 16'h0;
        cnt_pend  = 1'b0;
        tick(2);

        check_bus("rst", 1'b0, 1'b1, 2'd0, 32'h0);
        check("rst_valid", 32'(ev_valid), 32'd0);
        check("rst_edges", 32'(ev_edges), 32'd0);
        check("rst_levels", 32'(ev_levels), 32'd0);
        check("rst_count", 32'(ev_count), 32'd0);

        reset_n = 1'b1;
        tick(1);
        check_bus("init", 1'b1, 1'b0, 2'd2, 32'hF);
        tick(1);
        check_bus("idle", 1'b0, 1'b1, 2'd0, 32'h0);
        check("pio_mask", 32'(pio_mask), 32'hF);

        // Basic event, consumer always ready
        ev_ready = 1'b1;
        send(4'b0101, 4'b1010);
        check("irq_seen", 32'(irq), 32'd1);
        wait_valid("ev1_valid", lat);
        check("latency", 32'(lat), 32'd7);
        check_bus("out", 1'b0, 1'b1, 2'd0, 32'h0);
        tick(2);
        check("cnt_after_ev1", 32'(ev_count), 32'd1);

        // Back-pressure for 5 cycles
        ev_ready = 1'b0;
        send(4'b0011, 4'b0110);
        wait_valid("ev2_valid", lat);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("stall_valid", 32'(ev_valid), 32'd1);
            check("stall_edges", 32'(ev_edges), 32'h3);
            check("stall_levels", 32'(ev_levels), 32'h6);
            check("stall_count", 32'(ev_count), 32'd1);
        end
        ev_ready = 1'b1;
        tick(1);
        check("hs_valid_low", 32'(ev_valid), 32'd0);
        check("hs_count", 32'(ev_count), 32'd2);

        // Spurious irq: full bus walk, no event
        seq[0] = 5'b01111;
        seq[1] = 5'b01111;
        seq[2] = 5'b01011;
        seq[3] = 5'b01100;
        seq[4] = 5'b01100;
        seq[5] = 5'b00100;
        irq_force = 1'b1;
        tick(1);
        irq_force = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("spur_bus",
                  32'({ev_valid, chipselect, write_n, address}),
                  32'(seq[i]));
        end
        tick(3);
        check("spur_valid", 32'(ev_valid), 32'd0);
        check("spur_count", 32'(ev_count), 32'd2);

        // Reset during CLR
        send(4'b1100, 4'b0001);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (chipselect && !write_n && address == 2'd3)
                found = 1;
            else
                tick(1);
        end
        check("clr_seen", 32'(found), 32'd1);
        reset_n = 1'b0;
        #1;
        sb.delete();
        exp_cnt = 16'h0;
        check_bus("arst", 1'b0, 1'b1, 2'd0, 32'h0);
        check("arst_valid", 32'(ev_valid), 32'd0);
        check("arst_edges", 32'(ev_edges), 32'd0);
        check("arst_levels", 32'(ev_levels), 32'd0);
        check("arst_count", 32'(ev_count), 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        check_bus("reinit", 1'b1, 1'b0, 2'd2, 32'hF);
        tick(10);
        check("post_rst_valid", 32'(ev_valid), 32'd0);

        // Counter wrap from 16'hFFFF
        force dut.ev_count = 16'hFFFF;
        tick(1);
        release dut.ev_count;
        exp_cnt = 16'hFFFF;
        tick(1);
        check("preload", 32'(ev_count), 32'hFFFF);
        send(4'b1000, 4'b0111);
        wait_valid("ev_wrap_valid", lat);
        tick(2);
        check("wrap_count", 32'(ev_count), 32'd0);
        send(4'b0001, 4'b1111);
        wait_valid("ev_post_wrap", lat);
        tick(2);
        check("post_wrap_count", 32'(ev_count), 32'd1);

        for (int i = 0; i < 20 && sb.size() != 0; i++)
            tick(1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
